// File: rtl/game_pkg.sv
// Shared definitions for the collision game slice.
//   game_state_t : state encoding driven onto game_state (0 IDLE .. 4 WIN)
//   H_ACTIVE / V_ACTIVE : visible screen size in pixels
//   BLACK / CRASH_RED   : colour constants used by the overlay path
//   in_active()         : true when a pixel position lies inside the visible area
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_CRASH     = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } game_state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [11:0] BLACK     = 12'h000;
    localparam logic [11:0] CRASH_RED = 12'hF00;

    function automatic logic in_active(input logic [9:0] row, input logic [9:0] col);
        return (row < 10'(V_ACTIVE)) && (col < 10'(H_ACTIVE));
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-start detector.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   pix_row, pix_col  : display-timing pixel position (may hold several clks)
//   frame_tick        : one-clk pulse in the first cycle the position is (0,0)
module frame_tick_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_row,
    input  logic [9:0] pix_col,
    output logic       frame_tick
);

    logic at_origin;
    logic at_origin_reg;

    assign at_origin = (pix_row == 10'd0) && (pix_col == 10'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            at_origin_reg <= 1'b0;
        end else begin
            at_origin_reg <= at_origin;
        end
    end

    // Edge of "at origin", so a position parked at (0,0) yields only one pulse.
    assign frame_tick = at_origin && !at_origin_reg;

endmodule

// File: rtl/collision_game_ctrl.sv
// Collision game controller: detects sustained player/obstacle overlap,
// runs the IDLE/PLAYING/CRASH/GAME_OVER/WIN flow and tracks lives.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   pix_row, pix_col   : current pixel position
//   moving_cars_in     : obstacle pixel colour (0 = none)
//   player_car_in      : player pixel colour (0 = none)
//   score_in           : dodged-car score
//   start_btn          : debounced start button (rising edge acts)
//   game_state         : registered state code (see game_pkg)
//   lives_out          : registered lives remaining
//   freeze             : registered, high in every state except PLAYING
//   overlay_out        : crash flash colour, OR-ed into the video mux
// Build option: define COLLISION_FLASH_EN to enable the red crash flash;
// otherwise overlay_out is tied to 0.
module collision_game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int HIT_FRAMES   = 2,
    parameter int CRASH_FRAMES = 60,
    parameter int WIN_SCORE    = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic [11:0] moving_cars_in,
    input  logic [11:0] player_car_in,
    input  logic [5:0]  score_in,
    input  logic        start_btn,
    output logic [2:0]  game_state,
    output logic [1:0]  lives_out,
    output logic        freeze,
    output logic [11:0] overlay_out
);

    localparam int HCW     = (HIT_FRAMES < 2) ? 1 : $clog2(HIT_FRAMES + 1);
    localparam int CCW_RAW = $clog2(CRASH_FRAMES + 1);
    // At least 4 bits so the flash can always use bit 3 of the crash counter.
    localparam int CCW     = (CCW_RAW < 4) ? 4 : CCW_RAW;

    game_state_t      state_reg;
    logic [1:0]       lives_reg;
    logic             hit_frame_reg;
    logic [HCW-1:0]   hit_cnt_reg;
    logic [CCW-1:0]   crash_cnt_reg;
    logic             start_prev_reg;
    logic [2:0]       game_state_reg;
    logic [1:0]       lives_out_reg;
    logic             freeze_reg;

    logic frame_tick;
    logic pixel_hit;
    logic start_rise;
    logic crash_confirm;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .frame_tick (frame_tick)
    );

    assign pixel_hit  = (moving_cars_in != 12'd0) && (player_car_in != 12'd0) &&
                        in_active(pix_row, pix_col);
    assign start_rise = start_btn && !start_prev_reg;

    // Confirmed on the tick where the counter would reach HIT_FRAMES.
    assign crash_confirm = frame_tick && (state_reg == ST_PLAYING) && hit_frame_reg &&
                           (hit_cnt_reg >= HCW'(HIT_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            lives_reg      <= 2'(LIVES);
            hit_frame_reg  <= 1'b0;
            hit_cnt_reg    <= '0;
            crash_cnt_reg  <= '0;
            start_prev_reg <= 1'b0;
            game_state_reg <= ST_IDLE;
            lives_out_reg  <= 2'(LIVES);
            freeze_reg     <= 1'b1;
        end else begin
            start_prev_reg <= start_btn;

            // On the tick the old frame's latch is consumed; a hit in this very
            // cycle starts the next frame's latch.
            if (frame_tick) begin
                hit_frame_reg <= pixel_hit;
            end else if (pixel_hit) begin
                hit_frame_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    hit_cnt_reg <= '0;
                    if (start_rise) begin
                        state_reg <= ST_PLAYING;
                        lives_reg <= 2'(LIVES);
                    end
                end
                ST_PLAYING: begin
                    if (frame_tick) begin
                        if (!hit_frame_reg) begin
                            hit_cnt_reg <= '0;
                        end else if (hit_cnt_reg < HCW'(HIT_FRAMES)) begin
                            hit_cnt_reg <= hit_cnt_reg + 1'b1;
                        end
                    end
                    if (crash_confirm) begin
                        state_reg     <= ST_CRASH;
                        crash_cnt_reg <= CCW'(CRASH_FRAMES);
                        if (lives_reg != 2'd0) begin
                            lives_reg <= lives_reg - 1'b1;
                        end
                    end else if (score_in >= 6'(WIN_SCORE)) begin
                        state_reg <= ST_WIN;
                    end
                end
                ST_CRASH: begin
                    hit_cnt_reg <= '0;
                    if (frame_tick) begin
                        // Leaving on the tick that brings the count to zero gives
                        // exactly CRASH_FRAMES ticks in this state.
                        if (crash_cnt_reg <= CCW'(1)) begin
                            crash_cnt_reg <= '0;
                            state_reg     <= (lives_reg != 2'd0) ? ST_PLAYING : ST_GAME_OVER;
                        end else begin
                            crash_cnt_reg <= crash_cnt_reg - 1'b1;
                        end
                    end
                end
                ST_GAME_OVER, ST_WIN: begin
                    hit_cnt_reg <= '0;
                    if (start_rise) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    hit_cnt_reg <= '0;
                end
            endcase

            game_state_reg <= state_reg;
            lives_out_reg  <= lives_reg;
            freeze_reg     <= (state_reg != ST_PLAYING);
        end
    end

    assign game_state = game_state_reg;
    assign lives_out  = lives_out_reg;
    assign freeze     = freeze_reg;

`ifdef COLLISION_FLASH_EN
    logic [11:0] overlay_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            overlay_reg <= BLACK;
        end else begin
            overlay_reg <= ((state_reg == ST_CRASH) && (player_car_in != 12'd0) &&
                            crash_cnt_reg[3]) ? CRASH_RED : BLACK;
        end
    end

    assign overlay_out = overlay_reg;
`else
    assign overlay_out = BLACK;
`endif

endmodule

// File: tb/tb_collision_game_ctrl.sv
module tb_collision_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pix_row, pix_col;
    logic [11:0] moving_cars_in, player_car_in;
    logic [5:0]  score_in;
    logic        start_btn;
    logic [2:0]  game_state;
    logic [1:0]  lives_out;
    logic        freeze;
    logic [11:0] overlay_out;

    int checks = 0;
    int passes = 0;

`ifdef COLLISION_FLASH_EN
    localparam logic [11:0] FLASH_EXP = 12'hF00;
`else
    localparam logic [11:0] FLASH_EXP = 12'h000;
`endif

    collision_game_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .pix_row        (pix_row),
        .pix_col        (pix_col),
        .moving_cars_in (moving_cars_in),
        .player_car_in  (player_car_in),
        .score_in       (score_in),
        .start_btn      (start_btn),
        .game_state     (game_state),
        .lives_out      (lives_out),
        .freeze         (freeze),
        .overlay_out    (overlay_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One short frame: tick cycle, an active pixel (overlap if hit=1), then
    // two overlapping pixels just outside the visible area (row 480, col 640).
    task automatic do_frame(input logic hit, input logic [5:0] score_at_tick);
        pix_row = 10'd0; pix_col = 10'd0; moving_cars_in = 12'h000;
        player_car_in = 12'h0F0; score_in = score_at_tick;
        step();
        score_in = 6'd0;
        pix_row = 10'd10; pix_col = 10'd10; moving_cars_in = hit ? 12'h00F : 12'h000;
        step();
        pix_row = 10'd480; pix_col = 10'd5; moving_cars_in = 12'h00F;
        step();
        pix_row = 10'd5; pix_col = 10'd640;
        step();
        moving_cars_in = 12'h000;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) do_frame(1'b0, 6'd0);
    endtask

    task automatic start_pulse();
        start_btn = 1'b1; step();
        start_btn = 1'b0; step();
    endtask

    task automatic crash_now();
        do_frame(1'b1, 6'd0);
        do_frame(1'b1, 6'd0);
        do_frame(1'b0, 6'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_btn = 1'b0; score_in = 6'd0;
        pix_row = 10'd5; pix_col = 10'd640; moving_cars_in = 12'h0; player_car_in = 12'h0;
        step(); step();
        reset = 1'b0;
        checks++; if (game_state !== 3'd0) $display("FAIL reset_state got %0d exp 0", game_state); else passes++;
        checks++; if (lives_out !== 2'd3) $display("FAIL reset_lives got %0d exp 3", lives_out); else passes++;
        checks++; if (freeze !== 1'b1) $display("FAIL reset_freeze got %0b exp 1", freeze); else passes++;
        checks++; if (overlay_out !== 12'h000) $display("FAIL reset_overlay got %h exp 000", overlay_out); else passes++;
        $display("reset: state=%0d lives=%0d freeze=%0b", game_state, lives_out, freeze);
    endtask

    task automatic test_start();
        start_btn = 1'b1; step();
        checks++; if (game_state !== 3'd0) $display("FAIL start_latency got %0d exp 0", game_state); else passes++;
        step();
        checks++; if (game_state !== 3'd1) $display("FAIL start_state got %0d exp 1", game_state); else passes++;
        checks++; if (lives_out !== 2'd3) $display("FAIL start_lives got %0d exp 3", lives_out); else passes++;
        checks++; if (freeze !== 1'b0) $display("FAIL start_freeze got %0b exp 0", freeze); else passes++;
        step(); step();
        start_btn = 1'b0; step();
        $display("start: state=%0d lives=%0d freeze=%0b", game_state, lives_out, freeze);
    endtask

    task automatic test_single_hit();
        do_frame(1'b1, 6'd0);
        idle_frames(3);
        checks++; if (game_state !== 3'd1) $display("FAIL single_hit_state got %0d exp 1", game_state); else passes++;
        checks++; if (lives_out !== 2'd3) $display("FAIL single_hit_lives got %0d exp 3", lives_out); else passes++;
        $display("single-frame overlap: state=%0d lives=%0d", game_state, lives_out);
    endtask

    task automatic test_crash();
        crash_now();
        checks++; if (game_state !== 3'd2) $display("FAIL crash_state got %0d exp 2", game_state); else passes++;
        checks++; if (lives_out !== 2'd2) $display("FAIL crash_lives got %0d exp 2", lives_out); else passes++;
        checks++; if (freeze !== 1'b1) $display("FAIL crash_freeze got %0b exp 1", freeze); else passes++;
        checks++; if (overlay_out !== FLASH_EXP) $display("FAIL crash_overlay got %h exp %h", overlay_out, FLASH_EXP); else passes++;
        idle_frames(59);
        checks++; if (game_state !== 3'd2) $display("FAIL crash_59_state got %0d exp 2", game_state); else passes++;
        checks++; if (overlay_out !== 12'h000) $display("FAIL crash_59_overlay got %h exp 000", overlay_out); else passes++;
        idle_frames(1);
        checks++; if (game_state !== 3'd1) $display("FAIL crash_60_state got %0d exp 1", game_state); else passes++;
        checks++; if (lives_out !== 2'd2) $display("FAIL crash_60_lives got %0d exp 2", lives_out); else passes++;
        $display("crash: recovered state=%0d lives=%0d", game_state, lives_out);
    endtask

    task automatic test_game_over();
        crash_now(); idle_frames(60);
        checks++; if (lives_out !== 2'd1) $display("FAIL second_crash_lives got %0d exp 1", lives_out); else passes++;
        crash_now();
        checks++; if (lives_out !== 2'd0) $display("FAIL last_crash_lives got %0d exp 0", lives_out); else passes++;
        idle_frames(59);
        checks++; if (game_state !== 3'd2) $display("FAIL last_crash_59 got %0d exp 2", game_state); else passes++;
        idle_frames(1);
        checks++; if (game_state !== 3'd3) $display("FAIL game_over_state got %0d exp 3", game_state); else passes++;
        checks++; if (freeze !== 1'b1) $display("FAIL game_over_freeze got %0b exp 1", freeze); else passes++;
        // Held button: one transition only.
        start_btn = 1'b1; step(); step();
        checks++; if (game_state !== 3'd0) $display("FAIL over_to_idle got %0d exp 0", game_state); else passes++;
        step(); step(); step();
        checks++; if (game_state !== 3'd0) $display("FAIL held_start got %0d exp 0", game_state); else passes++;
        start_btn = 1'b0; step();
        $display("game over: returned to state=%0d", game_state);
    endtask

    task automatic test_frame_tick();
        int ticks = 0;
        pix_row = 10'd3; pix_col = 10'd3; step();
        for (int i = 0; i < 4; i++) begin
            pix_row = 10'd0; pix_col = 10'd0;
            #1;
            if (dut.frame_tick === 1'b1) ticks++;
            step();
        end
        pix_row = 10'd5; pix_col = 10'd640; step();
        checks++; if (ticks !== 1) $display("FAIL held_origin_ticks got %0d exp 1", ticks); else passes++;
        $display("frame tick: %0d pulse(s) over 4 held clks", ticks);
    endtask

    task automatic test_priority_and_reset();
        start_pulse();
        checks++; if (game_state !== 3'd1) $display("FAIL restart_state got %0d exp 1", game_state); else passes++;
        do_frame(1'b1, 6'd0);
        do_frame(1'b1, 6'd0);
        do_frame(1'b0, 6'd40);
        checks++; if (game_state !== 3'd2) $display("FAIL crash_priority got %0d exp 2", game_state); else passes++;
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (game_state !== 3'd0) $display("FAIL mid_crash_reset_state got %0d exp 0", game_state); else passes++;
        checks++; if (lives_out !== 2'd3) $display("FAIL mid_crash_reset_lives got %0d exp 3", lives_out); else passes++;
        // Reset taken with an overlap latched must leave no residual count.
        start_pulse();
        do_frame(1'b1, 6'd0);
        reset = 1'b1; step(); reset = 1'b0;
        start_pulse();
        do_frame(1'b1, 6'd0);
        do_frame(1'b0, 6'd0);
        checks++; if (game_state !== 3'd1) $display("FAIL residual_hit got %0d exp 1", game_state); else passes++;
        $display("priority/reset: state=%0d lives=%0d", game_state, lives_out);
    endtask

    task automatic test_win();
        score_in = 6'd39; step(); step(); step();
        checks++; if (game_state !== 3'd1) $display("FAIL score_39 got %0d exp 1", game_state); else passes++;
        score_in = 6'd40; step(); step();
        checks++; if (game_state !== 3'd4) $display("FAIL win_state got %0d exp 4", game_state); else passes++;
        checks++; if (freeze !== 1'b1) $display("FAIL win_freeze got %0b exp 1", freeze); else passes++;
        score_in = 6'd0;
        start_pulse(); step();
        checks++; if (game_state !== 3'd0) $display("FAIL win_to_idle got %0d exp 0", game_state); else passes++;
        $display("win: final state=%0d", game_state);
    endtask

    initial begin
        test_reset();
        test_start();
        test_single_hit();
        test_crash();
        test_game_over();
        test_frame_tick();
        test_priority_and_reset();
        test_win();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
